// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard/flush controller.
//   hz_state_e   : controller state (RUN, STALL)
//   REG_ZERO     : hard-wired zero register; it never creates a dependency
//   MEM_READ_BIT : position of the MEM-read bit inside the 2-bit ID/EX MEM
//                  control field (the EX-stage load indication is taken from
//                  this bit)
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam logic [2:0]  REG_ZERO     = 3'd0;
  localparam int unsigned MEM_FIELD_W  = 2;
  localparam int unsigned MEM_READ_BIT = 1;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for debug statistics. It holds at all-ones
// instead of wrapping. A clear wins over an increment in the same cycle.
//   clk_i   in   clock
//   rst_n   in   synchronous active-low reset (counter -> 0)
//   i_inc   in   count one event this cycle
//   i_clr   in   synchronous clear
//   o_cnt   out  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and flush controller for the 16-bit 5-stage pipeline. Detects
// load-use hazards (ID instruction reading the destination of a load in EX)
// and taken branches/jumps resolved in EX, and drives the write-enable and
// flush inputs of the PC, IF/ID and ID/EX registers. Outputs are Mealy: they
// respond in the same cycle the hazard is visible.
// Parameters:
//   LU_STALL_CYCLES  bubbles inserted per load-use hazard (1..7)
//   CNT_W            width of the statistics counters
// Ports:
//   clk_i, rst_n                 clock, synchronous active-low reset
//   id_rs_reg/id_rt_reg          source registers of the ID instruction
//   id_uses_rs/id_uses_rt        ID instruction actually reads RS/RT
//   ex_mem_read, ex_rt_reg       EX instruction is a load, and its target
//   ex_branch_taken, ex_jump     control-flow redirect resolved in EX
//   stat_clr_i                   clear both statistics counters
//   pc_write_o, if_id_write_o    PC / IF/ID update enables
//   data_id_ex_flush_o           load-use bubble into ID/EX
//   branch_if_id_flush_o         squash IF/ID on redirect
//   branch_id_ex_flush_o         squash ID/EX on redirect
//   stall_cnt_o, flush_cnt_o     saturating bubble / redirect counts
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [2:0]       id_rs_reg,
  input  logic [2:0]       id_rt_reg,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_rt_reg,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             stat_clr_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             data_id_ex_flush_o,
  output logic             branch_if_id_flush_o,
  output logic             branch_id_ex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // The first bubble is issued from RUN, so STALL covers the remaining
  // LU_STALL_CYCLES-1 cycles; rem counts down to 0 on the last of them.
  localparam logic [2:0] LU_REM_INIT =
    (LU_STALL_CYCLES > 1) ? 3'(LU_STALL_CYCLES - 2) : 3'd0;

  hz_state_e  r_state;
  hz_state_e  w_next_state;
  logic [2:0] r_rem;
  logic [2:0] w_next_rem;

  logic w_redirect;
  logic w_lu_hit;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_redirect = ex_branch_taken | ex_jump;
  assign w_lu_hit   = ex_mem_read && (ex_rt_reg != REG_ZERO) &&
                      ((id_uses_rs && (id_rs_reg == ex_rt_reg)) ||
                       (id_uses_rt && (id_rt_reg == ex_rt_reg)));

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_rem   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state         = r_state;
    w_next_rem           = r_rem;
    pc_write_o           = 1'b1;
    if_id_write_o        = 1'b1;
    data_id_ex_flush_o   = 1'b0;
    branch_if_id_flush_o = 1'b0;
    branch_id_ex_flush_o = 1'b0;
    w_stall_inc          = 1'b0;
    w_flush_inc          = 1'b0;

    unique case (r_state)
      RUN: begin
        // A redirect wins: the ID instruction is wrong-path, so its load-use
        // dependency is irrelevant.
        if (w_redirect) begin
          branch_if_id_flush_o = 1'b1;
          branch_id_ex_flush_o = 1'b1;
          w_flush_inc          = 1'b1;
        end else if (w_lu_hit) begin
          pc_write_o         = 1'b0;
          if_id_write_o      = 1'b0;
          data_id_ex_flush_o = 1'b1;
          w_stall_inc        = 1'b1;
          if (LU_STALL_CYCLES > 1) begin
            w_next_state = STALL;
            w_next_rem   = LU_REM_INIT;
          end
        end
      end
      STALL: begin
        // EX holds a bubble here, so its inputs are deliberately ignored.
        pc_write_o         = 1'b0;
        if_id_write_o      = 1'b0;
        data_id_ex_flush_o = 1'b1;
        w_stall_inc        = 1'b1;
        if (r_rem == 3'd0) begin
          w_next_state = RUN;
        end else begin
          w_next_rem = r_rem - 3'd1;
        end
      end
      default: begin
        w_next_state = RUN;
      end
    endcase

    if (!rst_n) begin
      pc_write_o           = 1'b0;
      if_id_write_o        = 1'b0;
      data_id_ex_flush_o   = 1'b0;
      branch_if_id_flush_o = 1'b0;
      branch_id_ex_flush_o = 1'b0;
      w_stall_inc          = 1'b0;
      w_flush_inc          = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .i_inc (w_stall_inc),
    .i_clr (stat_clr_i),
    .o_cnt (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .i_inc (w_flush_inc),
    .i_clr (stat_clr_i),
    .o_cnt (flush_cnt_o)
  );

endmodule : hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and flush controller for the 16-bit 5-stage pipeline. It drives the flush and write-enable inputs of the PC, IF/ID and ID/EX stage registers. It detects load-use hazards between the ID-stage instruction and a load in EX, and taken branches/jumps resolved in EX. It inserts the required bubbles and keeps saturating stall and flush statistics for debug.

## Interface
Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, width of statistics counters.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_rs_reg  in  3  RS register index of the instruction in ID.
- id_rt_reg  in  3  RT register index of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads RS.
- id_uses_rt  in  1  ID instruction reads RT.
- ex_mem_read  in  1  instruction in EX is a load (ID/EX MEM read bit).
- ex_rt_reg  in  3  load destination register of the EX instruction.
- ex_branch_taken  in  1  branch in EX resolved taken.
- ex_jump  in  1  jump in EX.
- stat_clr_i  in  1  synchronous clear of both counters.
- pc_write_o  out  1  PC update enable.
- if_id_write_o  out  1  IF/ID update enable.
- data_id_ex_flush_o  out  1  load-use bubble into ID/EX.
- branch_if_id_flush_o  out  1  squash IF/ID.
- branch_id_ex_flush_o  out  1  squash ID/EX.
- stall_cnt_o  out  CNT_W  number of bubble cycles inserted.
- flush_cnt_o  out  CNT_W  number of redirects.

## Operation
- States: RUN, STALL. Down-counter `rem` is 3 bits.
- redirect = ex_branch_taken | ex_jump.
- lu_hit = ex_mem_read & ex_rt_reg != 0 & ((id_uses_rs & id_rs_reg == ex_rt_reg) | (id_uses_rt & id_rt_reg == ex_rt_reg)). Register 0 never causes a hazard.
- RUN, redirect:
  - Priority over lu_hit, because the ID instruction is wrong-path.
  - pc_write_o=1, if_id_write_o=1, branch_if_id_flush_o=1, branch_id_ex_flush_o=1, data_id_ex_flush_o=0.
  - flush_cnt increments. State stays RUN.
- RUN, lu_hit, no redirect:
  - pc_write_o=0, if_id_write_o=0, data_id_ex_flush_o=1. stall_cnt increments.
  - If LU_STALL_CYCLES>1: go to STALL with rem=LU_STALL_CYCLES-2. Otherwise stay in RUN.
- RUN, neither: pc_write_o=1, if_id_write_o=1, all flushes 0.
- STALL:
  - Same outputs as the lu_hit case. stall_cnt increments. All EX inputs are ignored, since EX holds a bubble.
  - If rem==0, go to RUN. Otherwise decrement rem.
- Counters:
  - Saturate at all-ones, with no wrap.
  - stat_clr_i has priority over an increment in the same cycle: the result is 0.
- Outputs are Mealy (combinational from state and inputs). The consuming registers sample them on the same edge.

## Timing
- Detection-to-action latency is 0 cycles. Flush/enable outputs are valid in the same cycle the hazard is visible.
- A load-use hazard costs exactly LU_STALL_CYCLES bubbles. The ID instruction re-evaluates in the following RUN cycle; with the load now in MEM, it normally finds no hit.
- A redirect costs 2 squashed slots (IF/ID and ID/EX) in one cycle.
- Reset:
  - While rst_n=0, all outputs except the counters are driven to 0.
  - On a clock edge with rst_n=0: state becomes RUN, rem becomes 0, both counters become 0.
  - Reset in STALL aborts the stall immediately.
- A redirect and a lu_hit in the same RUN cycle produce redirect behaviour only. stall_cnt is unchanged.

## Structure
- hazard_pkg holds:
  - the state enum (RUN, STALL);
  - REG_ZERO = 3'd0;
  - the control-bit position of MEM read within the 2-bit MEM field.
- Sub-module sat_counter (CNT_W, inc, clr) is instantiated twice.

## Test plan
- ex_mem_read=1, ex_rt_reg=3, id_rs_reg=3, id_uses_rs=1, LU_STALL_CYCLES=1 -> one cycle with pc_write_o=0, if_id_write_o=0, data_id_ex_flush_o=1; stall_cnt_o=1 after the edge; next cycle RUN with enables 1.
- Same hazard with LU_STALL_CYCLES=3 -> 3 consecutive stall cycles, stall_cnt_o=3, then RUN.
- ex_rt_reg=0 matching id_rs_reg=0 -> no stall, all flushes 0.
- ex_branch_taken=1 together with a lu_hit -> both branch flushes=1, data flush=0, pc_write_o=1, flush_cnt_o=1, stall_cnt_o=0.
- rst_n=0 during the 2nd cycle of a 3-cycle stall -> all outputs 0 while low; after release, state RUN, counters 0, enables 1.
- Preload a counter near saturation with CNT_W=4 and drive 20 redirects -> flush_cnt_o holds at 15; stat_clr_i asserted together with a redirect -> 0.
